// File: rtl/rns_prodsum_batch_pkg.sv
// +--------------------------------------------------------------------------+
// | rns_prodsum_pkg: moduli table, FSM state encoding and lane modulus lookup |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package rns_prodsum_pkg;

  localparam int unsigned NUM_MODULI = 10;
  localparam int unsigned RNS_MODULI [0:9] = '{
    262139, 262133, 262127, 262121, 262111,
    262109, 262103, 262079, 262069, 262051
  };

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Lanes beyond the table reuse it cyclically so any NUM_DIGS elaborates.
  function automatic int unsigned lane_modulus(input int unsigned lane);
    return RNS_MODULI[lane % NUM_MODULI];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rns_prodsum_batch_if.sv
// +--------------------------------------------------------------------------+
// | rns_prodsum_batch_if: operand and result valid/ready bus                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface rns_prodsum_batch_if #(
  parameter int NUM_DIGS = 10,
  parameter int DIG_W    = 18,
  parameter int CNT_W    = 10
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_DIGS*DIG_W-1:0] dig_a;
  logic [NUM_DIGS*DIG_W-1:0] dig_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_DIGS*DIG_W-1:0] out_dig;
  logic [CNT_W-1:0]          batch_idx;

  modport master (
    output in_valid, dig_a, dig_b, out_ready,
    input  in_ready, out_valid, out_dig, batch_idx
  );

  modport slave (
    input  in_valid, dig_a, dig_b, out_ready,
    output in_ready, out_valid, out_dig, batch_idx
  );
endinterface

`default_nettype wire

// File: rtl/rns_mac_lane.sv
// +--------------------------------------------------------------------------+
// | rns_mac_lane: one digit lane, multiply -> reduce -> modular accumulate   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rns_mac_lane #(
  parameter int          DIG_W   = 18,
  parameter int unsigned MODULUS = 262139
) (
  input  wire logic             clk,
  input  wire logic             aclr,
  input  wire logic             vld,
  input  wire logic             first,
  input  wire logic [DIG_W-1:0] a,
  input  wire logic [DIG_W-1:0] b,
  output logic      [DIG_W-1:0] acc,
  output logic                  pipe_busy
);

  localparam logic [2*DIG_W-1:0] MOD_P = (2*DIG_W)'(MODULUS);
  localparam logic [DIG_W:0]     MOD_S = (DIG_W+1)'(MODULUS);

  logic [2*DIG_W-1:0] prod;
  logic [DIG_W-1:0]   red;
  logic               v1, f1, v2, f2;
  logic [DIG_W-1:0]   base;
  logic [DIG_W:0]     sum;

  // acc and red are both below the modulus, so one conditional subtract suffices.
  assign base      = f2 ? '0 : acc;
  assign sum       = {1'b0, base} + {1'b0, red};
  assign pipe_busy = v1 | v2;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      prod <= '0;
      red  <= '0;
      acc  <= '0;
      v1   <= 1'b0;
      f1   <= 1'b0;
      v2   <= 1'b0;
      f2   <= 1'b0;
    end else begin
      v1 <= vld;
      f1 <= first;
      v2 <= v1;
      f2 <= f1;
      if (vld) prod <= (2*DIG_W)'(a) * (2*DIG_W)'(b);
      if (v1)  red  <= DIG_W'(prod % MOD_P);
      if (v2)  acc  <= (sum >= MOD_S) ? DIG_W'(sum - MOD_S) : sum[DIG_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/rns_prodsum_batch.sv
// +--------------------------------------------------------------------------+
// | rns_prodsum_batch: batched RNS dot-product engine with valid/ready bus   |
// | Option macro: RNS_PRODSUM_RANGE_CHECK_EN adds sticky range_err flags     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rns_prodsum_batch
  import rns_prodsum_pkg::*;
#(
  parameter int NUM_DIGS = 10,
  parameter int DIG_W    = 18,
  parameter int CNT_W    = 10
) (
  input  wire logic             clk,
  input  wire logic             aclr,
  input  wire logic             start,
  input  wire logic [CNT_W-1:0] num_prods,
  input  wire logic [CNT_W-1:0] num_batches,
  rns_prodsum_batch_if.slave    bus,
  output logic                  busy,
`ifdef RNS_PRODSUM_RANGE_CHECK_EN
  output logic [NUM_DIGS-1:0]   range_err,
`endif
  output logic                  done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                    state, state_nx;
  logic [CNT_W-1:0]          prod_cnt, batch_cnt, np_q, nb_q;
  logic [NUM_DIGS*DIG_W-1:0] acc_flat;
  logic [NUM_DIGS-1:0]       lane_busy;
  logic                      start_ok, xfer, last_xfer, out_hs, last_batch;

  assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
  assign xfer       = bus.in_valid && bus.in_ready;
  assign last_xfer  = xfer && (prod_cnt == np_q - CNT_ONE);
  assign out_hs     = bus.out_valid && bus.out_ready;
  assign last_batch = (batch_cnt == nb_q - CNT_ONE);

  assign bus.in_ready  = (state == ST_RUN) && (prod_cnt < np_q);
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.out_dig   = bus.out_valid ? acc_flat : '0;
  assign bus.batch_idx = batch_cnt;
  assign busy          = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_HOLD);
  assign done          = (state == ST_DONE);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start)           state_nx = ST_RUN;
      ST_RUN:           if (last_xfer)       state_nx = ST_DRAIN;
      ST_DRAIN:         if (~|lane_busy)     state_nx = ST_HOLD;
      ST_HOLD:          if (out_hs)          state_nx = last_batch ? ST_DONE : ST_RUN;
      default:                               state_nx = ST_IDLE;
    endcase
  end

  // A zero count is promoted to one so every run produces at least one result.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      prod_cnt  <= '0;
      batch_cnt <= '0;
      np_q      <= '0;
      nb_q      <= '0;
    end else if (start_ok) begin
      prod_cnt  <= '0;
      batch_cnt <= '0;
      np_q      <= (num_prods   == '0) ? CNT_ONE : num_prods;
      nb_q      <= (num_batches == '0) ? CNT_ONE : num_batches;
    end else begin
      if (xfer) prod_cnt <= prod_cnt + CNT_ONE;
      if (out_hs) begin
        prod_cnt  <= '0;
        batch_cnt <= batch_cnt + CNT_ONE;
      end
    end
  end

  for (genvar i = 0; i < NUM_DIGS; i++) begin : g_lane
    rns_mac_lane #(
      .DIG_W   (DIG_W),
      .MODULUS (lane_modulus(i))
    ) u_lane (
      .clk       (clk),
      .aclr      (aclr),
      .vld       (xfer),
      .first     (prod_cnt == '0),
      .a         (bus.dig_a[i*DIG_W +: DIG_W]),
      .b         (bus.dig_b[i*DIG_W +: DIG_W]),
      .acc       (acc_flat[i*DIG_W +: DIG_W]),
      .pipe_busy (lane_busy[i])
    );
  end

`ifdef RNS_PRODSUM_RANGE_CHECK_EN
  logic [NUM_DIGS-1:0] lane_oor;

  for (genvar i = 0; i < NUM_DIGS; i++) begin : g_range
    assign lane_oor[i] = (bus.dig_a[i*DIG_W +: DIG_W] >= DIG_W'(lane_modulus(i))) ||
                         (bus.dig_b[i*DIG_W +: DIG_W] >= DIG_W'(lane_modulus(i)));
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)          range_err <= '0;
    else if (start_ok) range_err <= '0;
    else if (xfer)     range_err <= range_err | lane_oor;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rns_prodsum_batch.sv
// +--------------------------------------------------------------------------+
// | tb_rns_prodsum_batch: directed vectors with queue-based result scoreboard |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rns_prodsum_batch;

  localparam int ND = 10;
  localparam int DW = 18;
  localparam int CW = 10;
  localparam int VW = ND * DW;
  localparam int unsigned MODS [0:9] = '{
    262139, 262133, 262127, 262121, 262111,
    262109, 262103, 262079, 262069, 262051
  };

  typedef struct packed {
    logic [VW-1:0] dig;
    logic [CW-1:0] idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          aclr, start, busy, done;
  logic [CW-1:0] num_prods, num_batches;
`ifdef RNS_PRODSUM_RANGE_CHECK_EN
  logic [ND-1:0] range_err;
`endif

  rns_prodsum_batch_if #(.NUM_DIGS(ND), .DIG_W(DW), .CNT_W(CW)) bus ();

  rns_prodsum_batch #(.NUM_DIGS(ND), .DIG_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .aclr        (aclr),
    .start       (start),
    .num_prods   (num_prods),
    .num_batches (num_batches),
    .bus         (bus),
    .busy        (busy),
`ifdef RNS_PRODSUM_RANGE_CHECK_EN
    .range_err   (range_err),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  int   cyc   = 0;
  int   xfers = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid && bus.in_ready) xfers <= xfers + 1;
  end

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input int unsigned v);
    logic [VW-1:0] r;
    for (int i = 0; i < ND; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] m_minus(input int unsigned k);
    logic [VW-1:0] r;
    for (int i = 0; i < ND; i++) r[i*DW +: DW] = DW'(MODS[i] - k);
    return r;
  endfunction

  task automatic push_exp(input logic [VW-1:0] dig, input int idx);
    exp_t e;
    e.dig = dig;
    e.idx = CW'(idx);
    q.push_back(e);
  endtask

  // Scoreboard monitor: pops one expectation per accepted result.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got batch_idx %0d expected none", bus.batch_idx);
      end else begin
        e = q.pop_front();
        check("out_dig", bus.out_dig, e.dig);
        check("batch_idx", VW'(bus.batch_idx), VW'(e.idx));
      end
    end
  end

  task automatic do_start(input int np, input int nb);
    @(negedge clk);
    num_prods   = CW'(np);
    num_batches = CW'(nb);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic feed(input int n, input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input bit gaps, output int xfer_edge);
    int sent = 0;
    int c    = 0;
    xfer_edge = 0;
    bus.dig_a = a;
    bus.dig_b = b;
    while (sent < n && c < 100) begin
      bus.in_valid = gaps ? (c % 3 == 0) : 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        sent++;
        xfer_edge = cyc + 1;
      end
      c++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("feed_count", VW'(sent), VW'(n));
  endtask

  task automatic wait_valid(output int at);
    int c = 0;
    while (!bus.out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("out_valid_seen", VW'(bus.out_valid), VW'(1));
    at = cyc;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int xe, at, base;
    logic [VW-1:0] snap_dig;
    logic [CW-1:0] snap_idx;
    aclr = 1'b1; start = 1'b0; num_prods = '0; num_batches = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.dig_a = '0; bus.dig_b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", VW'(bus.in_ready), '0);
    check("rst_out_valid", VW'(bus.out_valid), '0);
    check("rst_out_dig", bus.out_dig, '0);
    check("rst_batch_idx", VW'(bus.batch_idx), '0);
    check("rst_busy", VW'(busy), '0);
    check("rst_done", VW'(done), '0);
    aclr = 1'b0;
    @(negedge clk);

    // Basic: 4 x (3*5) = 60 on every lane, result 3 cycles after the last transfer
    bus.out_ready = 1'b1;
    push_exp(fill(60), 0);
    do_start(4, 1);
    check("run_busy", VW'(busy), VW'(1));
    feed(4, fill(3), fill(5), 1'b0, xe);
    wait_valid(at);
    check("latency", VW'(at - xe), VW'(3));
    @(negedge clk);
    check("basic_done", VW'(done), VW'(1));
    check("basic_idle_busy", VW'(busy), '0);

    // Modular wrap: 3 x (m-1)^2 = 3 mod m, then 2 x (m-1) = m-2
    push_exp(fill(3), 0);
    do_start(3, 1);
    feed(3, m_minus(1), m_minus(1), 1'b0, xe);
    wait_valid(at);
    push_exp(m_minus(2), 0);
    do_start(2, 1);
    feed(2, m_minus(1), fill(1), 1'b0, xe);
    wait_valid(at);
    @(negedge clk);
    check("wrap_done", VW'(done), VW'(1));

    // Back-pressure over 3 batches: batch k sums 2 x ((k+1)*2)
    bus.out_ready = 1'b0;
    do_start(2, 3);
    for (int k = 0; k < 3; k++) begin
      push_exp(fill(4 * (k + 1)), k);
      feed(2, fill(k + 1), fill(2), 1'b0, xe);
      wait_valid(at);
      snap_dig = bus.out_dig;
      snap_idx = bus.batch_idx;
      repeat (10) begin
        @(negedge clk);
        check("bp_dig_stable", bus.out_dig, snap_dig);
        check("bp_idx_stable", VW'(bus.batch_idx), VW'(snap_idx));
        check("bp_in_ready", VW'(bus.in_ready), '0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    check("bp_done", VW'(done), VW'(1));

    // Input gaps: 5 x (3*4) = 60, in_valid stays high through drain
    bus.out_ready = 1'b1;
    base = xfers;
    push_exp(fill(60), 0);
    do_start(5, 1);
    feed(5, fill(3), fill(4), 1'b1, xe);
    bus.in_valid = 1'b1;
    wait_valid(at);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("gap_xfer_count", VW'(xfers - base), VW'(5));
    check("gap_done", VW'(done), VW'(1));

    // Abort mid-run, then a fresh single-product run
    do_start(4, 1);
    feed(2, fill(9), fill(9), 1'b0, xe);
    aclr = 1'b1;
    @(negedge clk);
    check("abort_busy", VW'(busy), '0);
    check("abort_done", VW'(done), '0);
    check("abort_out_valid", VW'(bus.out_valid), '0);
    check("abort_out_dig", bus.out_dig, '0);
    check("abort_in_ready", VW'(bus.in_ready), '0);
    check("abort_batch_idx", VW'(bus.batch_idx), '0);
    aclr = 1'b0;
    push_exp(fill(14), 0);
    do_start(1, 1);
    feed(1, fill(7), fill(2), 1'b0, xe);
    wait_valid(at);
    @(negedge clk);
    check("abort_rerun_done", VW'(done), VW'(1));

`ifdef RNS_PRODSUM_RANGE_CHECK_EN
    begin
      logic [VW-1:0] a_bad;
      logic [VW-1:0] e_bad;
      a_bad = fill(1);
      a_bad[3*DW +: DW] = DW'(262143);
      e_bad = fill(1);
      e_bad[3*DW +: DW] = DW'(22);
      push_exp(e_bad, 0);
      do_start(1, 1);
      feed(1, a_bad, fill(1), 1'b0, xe);
      check("range_err_set", VW'(range_err), VW'(10'b0000001000));
      wait_valid(at);
      push_exp(fill(1), 0);
      do_start(1, 1);
      check("range_err_clear", VW'(range_err), '0);
      feed(1, fill(1), fill(1), 1'b0, xe);
      wait_valid(at);
      @(negedge clk);
    end
`endif

    for (int w = 0; w < 20 && q.size() != 0; w++) @(negedge clk);
    check("queue_empty", VW'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
